// File: rtl/ibex_fetch_req_ctrl_if.sv
// ibex_fetch_req_ctrl_if
//
// Bus bundle for the fetch request controller. It carries the OBI
// instruction-memory port and the push port into the fetch FIFO.
// Signal suffixes are from the controller's point of view.
//
// Modports:
//   master - the controller: drives the OBI request and the FIFO push,
//            and receives grant/response and FIFO occupancy.
//   slave  - the memory/FIFO side, with the directions reversed.
//
// Signals:
//   instr_req_o / instr_addr_o    OBI request and word address
//   instr_gnt_i                   OBI grant
//   instr_rvalid_i / instr_rdata_i / instr_err_i   OBI response
//   fifo_busy_i [NUM_REQS]        FIFO upper-entry occupancy
//   fifo_clear_o                  FIFO clear, pulses on a branch
//   fifo_valid_o / fifo_addr_o / fifo_rdata_o / fifo_err_o   FIFO push port
interface ibex_fetch_req_ctrl_if #(
    parameter int unsigned NUM_REQS = 2
);
    logic                instr_req_o;
    logic [31:0]         instr_addr_o;
    logic                instr_gnt_i;
    logic                instr_rvalid_i;
    logic [31:0]         instr_rdata_i;
    logic                instr_err_i;

    logic [NUM_REQS-1:0] fifo_busy_i;
    logic                fifo_clear_o;
    logic                fifo_valid_o;
    logic [31:0]         fifo_addr_o;
    logic [31:0]         fifo_rdata_o;
    logic                fifo_err_o;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        input  fifo_busy_i,
        output fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
        output fifo_busy_i,
        input  fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o
    );
endinterface

// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl
//
// Request-side controller of the instruction prefetch path. It issues
// word-aligned OBI requests, tracks up to NUM_REQS outstanding transactions,
// forwards in-order responses into the fetch FIFO, drops responses made
// stale by a branch, and throttles new requests so the FIFO cannot overflow.
//
// Handshake: an OBI request, once raised, holds instr_req_o and instr_addr_o
// stable until the cycle with instr_gnt_i = 1; that same cycle completes the
// address phase (zero-latency grant allowed). A response (instr_rvalid_i) is
// accepted every cycle in which it is high and is pushed into the FIFO in
// that same cycle (fifo_valid_o), with no backpressure.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_i             fetch enable
//   branch_i          one-cycle redirect strobe
//   branch_addr_i     redirect target (halfword aligned)
//   bus               OBI + FIFO bundle (ibex_fetch_req_ctrl_if.master)
//   busy_o            a request is being issued, pending or outstanding
//   discard_cnt_o     number of dropped stale responses
//
// Configuration macro: IBEX_FETCH_DISCARD_CNT_EN builds the saturating
// 16-bit discard counter; when undefined discard_cnt_o is tied to zero.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    ibex_fetch_req_ctrl_if.master bus,
    output logic                  busy_o,
    output logic [15:0]           discard_cnt_o
);

    localparam int unsigned       CNT_W   = $clog2(NUM_REQS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(NUM_REQS);

    logic [31:2]         fetch_addr_q, fetch_addr_d;
    logic                pend_q, pend_d;
    logic [31:2]         pend_addr_q, pend_addr_d;
    logic                pend_disc_q, pend_disc_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [NUM_REQS-1:0] disc_q, disc_d;

    logic [CNT_W:0]      busy_cnt;
    logic [CNT_W:0]      occ_sum;
    logic                issue;
    logic                grant;
    logic                grant_stale;
    logic                rsp;
    logic                drop;
    logic [31:2]         new_addr;
    logic [31:2]         req_addr;
    logic [NUM_REQS-1:0] out_mask;
    logic [NUM_REQS-1:0] disc_tmp;
    logic [CNT_W-1:0]    cnt_tmp;

    // Request issue and response routing.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            busy_cnt = busy_cnt + {{CNT_W{1'b0}}, bus.fifo_busy_i[i]};
        end
        occ_sum = {1'b0, out_cnt_q} + busy_cnt;

        // FIFO occupancy is irrelevant in a branch cycle: the FIFO is cleared.
        issue = (req_i | branch_i) & ~pend_q & (out_cnt_q < MAX_CNT) &
                (branch_i | (occ_sum < {1'b0, MAX_CNT}));

        new_addr = branch_i ? branch_addr_i[31:2] : fetch_addr_q;
        req_addr = pend_q ? pend_addr_q : new_addr;

        bus.instr_req_o  = pend_q | issue;
        bus.instr_addr_o = {req_addr, 2'b00};

        grant       = bus.instr_req_o & bus.instr_gnt_i;
        // Only a request raised before the branch can be stale; a request
        // issued in the branch cycle is the branch target itself.
        grant_stale = pend_q & (pend_disc_q | branch_i);

        rsp  = bus.instr_rvalid_i & (out_cnt_q != '0);
        drop = rsp & (disc_q[0] | branch_i);

        bus.fifo_clear_o = branch_i;
        bus.fifo_addr_o  = branch_addr_i;
        bus.fifo_valid_o = rsp & ~drop;
        bus.fifo_rdata_o = bus.instr_rdata_i;
        bus.fifo_err_o   = bus.instr_err_i;

        busy_o = pend_q | issue | (out_cnt_q != '0);
    end

    // Outstanding-transaction tracking: disc_q[0] belongs to the oldest.
    always_comb begin
        out_mask = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            out_mask[i] = (CNT_W'(i) < out_cnt_q);
        end

        disc_tmp = disc_q | (branch_i ? out_mask : '0);
        cnt_tmp  = out_cnt_q;

        if (rsp) begin
            disc_tmp = disc_tmp >> 1;
            cnt_tmp  = cnt_tmp - CNT_W'(1);
        end

        if (grant) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CNT_W'(i) == cnt_tmp) begin
                    disc_tmp[i] = grant_stale;
                end
            end
            cnt_tmp = cnt_tmp + CNT_W'(1);
        end

        disc_d    = disc_tmp;
        out_cnt_d = cnt_tmp;
    end

    // Fetch address and pending-request bookkeeping.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        pend_disc_d  = pend_disc_q;

        if (branch_i) begin
            // The branch word advances only if it is the request granted now.
            fetch_addr_d = (grant & ~pend_q) ? branch_addr_i[31:2] + 30'd1
                                             : branch_addr_i[31:2];
        end else if (grant & ~grant_stale) begin
            fetch_addr_d = req_addr + 30'd1;
        end

        if (pend_q) begin
            pend_d      = ~bus.instr_gnt_i;
            pend_disc_d = ~bus.instr_gnt_i & (pend_disc_q | branch_i);
        end else begin
            pend_d      = issue & ~bus.instr_gnt_i;
            pend_addr_d = new_addr;
            pend_disc_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_disc_q  <= 1'b0;
            out_cnt_q    <= '0;
            disc_q       <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_disc_q  <= pend_disc_d;
            out_cnt_q    <= out_cnt_d;
            disc_q       <= disc_d;
        end
    end

`ifdef IBEX_FETCH_DISCARD_CNT_EN
    logic [15:0] discard_cnt_q, discard_cnt_d;

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (drop && (discard_cnt_q != 16'hFFFF)) begin
            discard_cnt_d = discard_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            discard_cnt_q <= '0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign discard_cnt_o = discard_cnt_q;
`else
    assign discard_cnt_o = '0;
`endif

    // A response with nothing outstanding is ignored by the logic above.
    rsp_without_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        bus.instr_rvalid_i |-> (out_cnt_q != '0));

    req_held_until_gnt : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (bus.instr_req_o && !bus.instr_gnt_i) |=>
        (bus.instr_req_o && $stable(bus.instr_addr_o)));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
module tb_ibex_fetch_req_ctrl;

    localparam int unsigned NUM_REQS = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req;
    logic        br;
    logic [31:0] br_addr;
    logic        busy;
    logic [15:0] disc_cnt;

    always #5 clk = ~clk;

    ibex_fetch_req_ctrl_if #(.NUM_REQS(NUM_REQS)) bus ();

    ibex_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .branch_i      (br),
        .branch_addr_i (br_addr),
        .bus           (bus),
        .busy_o        (busy),
        .discard_cnt_o (disc_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic b, input logic [31:0] ba,
                         input logic [NUM_REQS-1:0] fb, input logic g,
                         input logic rv, input logic [31:0] rd, input logic e);
        req                = r;
        br                 = b;
        br_addr            = ba;
        bus.fifo_busy_i    = fb;
        bus.instr_gnt_i    = g;
        bus.instr_rvalid_i = rv;
        bus.instr_rdata_i  = rd;
        bus.instr_err_i    = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int popc(input logic [NUM_REQS-1:0] v);
        int c = 0;
        for (int i = 0; i < NUM_REQS; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [31:0] mem_rdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return ^a[6:2];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.instr_req_o); end
        n_cmp++; if (bus.instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.instr_addr_o); end
        n_cmp++; if (bus.fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.fifo_valid_o); end
        n_cmp++; if (bus.fifo_clear_o !== 1'b0) begin n_fail++; $display("FAIL rst_clear: got %b want 0", bus.fifo_clear_o); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (disc_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_disc: got %h want 0", disc_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a [3];
        logic [31:0] rd;
        exp_a[0] = 32'h0; exp_a[1] = 32'h4; exp_a[2] = 32'h8;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rd = 32'h1111_0000 * (c + 1);
            drive(c < 3, 0, 32'h0, '0, c < 3, c > 0, rd, 0);
            @(negedge clk);
            if (c < 3) begin
                n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== exp_a[c]) begin
                    n_fail++; $display("FAIL seq_req%0d: got %b/%h want 1/%h", c, bus.instr_req_o, bus.instr_addr_o, exp_a[c]); end
            end
            n_cmp++; if (bus.fifo_valid_o !== (c > 0)) begin
                n_fail++; $display("FAIL seq_valid%0d: got %b want %b", c, bus.fifo_valid_o, c > 0); end
            if (c > 0) begin
                n_cmp++; if (bus.fifo_rdata_o !== rd) begin
                    n_fail++; $display("FAIL seq_rdata%0d: got %h want %h", c, bus.fifo_rdata_o, rd); end
            end
            tick();
        end
        drive(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_idle_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_max_outstanding();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
            @(negedge clk);
            n_cmp++; if (bus.instr_req_o !== (c < 2)) begin
                n_fail++; $display("FAIL max_req%0d: got %b want %b", c, bus.instr_req_o, c < 2); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL max_busy%0d: got %b want 1", c, busy); end
            tick();
        end
        drive(1, 0, 32'h0, '0, 1, 1, 32'hAAAA_0000, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL max_req_rsp: got %b want 0", bus.instr_req_o); end
        n_cmp++; if (bus.fifo_valid_o !== 1'b1 || bus.fifo_rdata_o !== 32'hAAAA_0000) begin
            n_fail++; $display("FAIL max_push: got %b/%h want 1/aaaa0000", bus.fifo_valid_o, bus.fifo_rdata_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 1, 32'hBBBB_0004, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h8) begin
            n_fail++; $display("FAIL max_next: got %b/%h want 1/00000008", bus.instr_req_o, bus.instr_addr_o); end
        tick();
    endtask

    task automatic test_fifo_busy();
        do_reset();
        drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 32'h0, 2'b01, 1, 0, 32'h0, 0);
            @(negedge clk);
            n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL fb_hold%0d: got %b want 0", c, bus.instr_req_o); end
            tick();
        end
        drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h4) begin
            n_fail++; $display("FAIL fb_release: got %b/%h want 1/00000004", bus.instr_req_o, bus.instr_addr_o); end
        tick();
        drive(0, 0, 32'h0, 2'b01, 0, 1, 32'h0, 0);
        tick();
        drive(1, 0, 32'h0, 2'b01, 1, 1, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL fb_rsp_cycle: got %b want 0", bus.instr_req_o); end
        tick();
        drive(1, 0, 32'h0, 2'b01, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h8) begin
            n_fail++; $display("FAIL fb_after_rsp: got %b/%h want 1/00000008", bus.instr_req_o, bus.instr_addr_o); end
        tick();
    endtask

    task automatic test_branch_discard();
        logic [15:0] exp_d;
        do_reset();
        drive(1, 1, 32'h100, '0, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_addr_o !== 32'h100 || bus.fifo_clear_o !== 1'b1) begin
            n_fail++; $display("FAIL br_first: got %h/%b want 00000100/1", bus.instr_addr_o, bus.fifo_clear_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_addr_o !== 32'h104 || bus.fifo_clear_o !== 1'b0) begin
            n_fail++; $display("FAIL br_second: got %h/%b want 00000104/0", bus.instr_addr_o, bus.fifo_clear_o); end
        tick();
        drive(1, 1, 32'h202, '0, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_clear_o !== 1'b1 || bus.fifo_addr_o !== 32'h202 || bus.instr_req_o !== 1'b0) begin
            n_fail++; $display("FAIL br_clear: got %b/%h/%b want 1/00000202/0", bus.fifo_clear_o, bus.fifo_addr_o, bus.instr_req_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 1, 32'hDEAD_0100, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL br_drop0: got %b want 0", bus.fifo_valid_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 1, 32'hDEAD_0104, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL br_drop1: got %b want 0", bus.fifo_valid_o); end
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200) begin
            n_fail++; $display("FAIL br_target: got %b/%h want 1/00000200", bus.instr_req_o, bus.instr_addr_o); end
        tick();
        drive(0, 0, 32'h0, '0, 0, 1, 32'hC0DE_0200, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_valid_o !== 1'b1 || bus.fifo_rdata_o !== 32'hC0DE_0200) begin
            n_fail++; $display("FAIL br_push: got %b/%h want 1/c0de0200", bus.fifo_valid_o, bus.fifo_rdata_o); end
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        exp_d = 16'd2;
`else
        exp_d = 16'd0;
`endif
        n_cmp++; if (disc_cnt !== exp_d) begin n_fail++; $display("FAIL br_disc_cnt: got %0d want %0d", disc_cnt, exp_d); end
        tick();
    endtask

    task automatic test_pending_branch();
        logic [15:0] exp_d;
        do_reset();
        drive(1, 1, 32'h40, '0, 0, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL pb_raise: got %b/%h want 1/00000040", bus.instr_req_o, bus.instr_addr_o); end
        tick();
        drive(1, 1, 32'h80, '0, 0, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h40 || bus.fifo_clear_o !== 1'b1) begin
            n_fail++; $display("FAIL pb_branch: got %b/%h/%b want 1/00000040/1", bus.instr_req_o, bus.instr_addr_o, bus.fifo_clear_o); end
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 32'h0, '0, c == 1, 0, 32'h0, 0);
            @(negedge clk);
            n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h40) begin
                n_fail++; $display("FAIL pb_hold%0d: got %b/%h want 1/00000040", c, bus.instr_req_o, bus.instr_addr_o); end
            tick();
        end
        drive(1, 0, 32'h0, '0, 1, 1, 32'h4040_4040, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL pb_drop: got %b want 0", bus.fifo_valid_o); end
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h80) begin
            n_fail++; $display("FAIL pb_target: got %b/%h want 1/00000080", bus.instr_req_o, bus.instr_addr_o); end
        tick();
        drive(0, 0, 32'h0, '0, 0, 1, 32'h8080_8080, 0);
        @(negedge clk);
        n_cmp++; if (bus.fifo_valid_o !== 1'b1 || bus.fifo_rdata_o !== 32'h8080_8080) begin
            n_fail++; $display("FAIL pb_push: got %b/%h want 1/80808080", bus.fifo_valid_o, bus.fifo_rdata_o); end
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        exp_d = 16'd1;
`else
        exp_d = 16'd0;
`endif
        n_cmp++; if (disc_cnt !== exp_d) begin n_fail++; $display("FAIL pb_disc_cnt: got %0d want %0d", disc_cnt, exp_d); end
        tick();
    endtask

    task automatic test_wrap_err();
        do_reset();
        drive(1, 1, 32'hFFFF_FFFE, '0, 1, 0, 32'h0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_addr_o !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_top: got %h want fffffffc", bus.instr_addr_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 1, 32'h1234_5678, 1);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", bus.instr_req_o, bus.instr_addr_o); end
        n_cmp++; if (bus.fifo_valid_o !== 1'b1 || bus.fifo_err_o !== 1'b1) begin
            n_fail++; $display("FAIL wrap_err: got %b/%b want 1/1", bus.fifo_valid_o, bus.fifo_err_o); end
        tick();
        drive(1, 0, 32'h0, '0, 1, 1, 32'h9ABC_DEF0, 0);
        @(negedge clk);
        n_cmp++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h4) begin
            n_fail++; $display("FAIL wrap_cont: got %b/%h want 1/00000004", bus.instr_req_o, bus.instr_addr_o); end
        n_cmp++; if (bus.fifo_valid_o !== 1'b1 || bus.fifo_err_o !== 1'b0 || bus.fifo_rdata_o !== 32'h9ABC_DEF0) begin
            n_fail++; $display("FAIL wrap_ok: got %b/%b/%h want 1/0/9abcdef0", bus.fifo_valid_o, bus.fifo_err_o, bus.fifo_rdata_o); end
        tick();
    endtask

    // Randomized traffic against a transaction-level model: a queue of
    // outstanding words with a stale flag each, plus one pending request.
    task automatic test_random();
        logic [31:0]         out_addr_q[$];
        logic                out_stale_q[$];
        logic [31:0]         m_fetch;
        logic                m_pend;
        logic [31:0]         m_pend_addr;
        logic                m_pend_stale;
        int                  m_drops;
        logic                r_req, r_br, r_gnt, r_rv, r_err;
        logic [31:0]         r_ba, r_rd, e_addr;
        logic [NUM_REQS-1:0] r_fb;
        logic                e_req, e_valid, e_busy, room, st;
        logic [15:0]         exp_d;

        do_reset();
        m_fetch = 32'h0; m_pend = 1'b0; m_pend_addr = 32'h0; m_pend_stale = 1'b0; m_drops = 0;

        for (int c = 0; c < 600; c++) begin
            r_req = ($urandom_range(0, 9) < 8);
            r_br  = ($urandom_range(0, 11) == 0);
            r_ba  = $urandom & 32'hFFFF_FFFE;
            r_fb  = ($urandom_range(0, 2) == 0) ? NUM_REQS'($urandom) : '0;
            r_gnt = ($urandom_range(0, 9) < 7);
            r_rv  = (out_addr_q.size() > 0) && ($urandom_range(0, 9) < 6);
            r_rd  = r_rv ? mem_rdata(out_addr_q[0]) : $urandom;
            r_err = r_rv ? mem_err(out_addr_q[0]) : 1'b0;
            drive(r_req, r_br, r_ba, r_fb, r_gnt, r_rv, r_rd, r_err);

            if (m_pend) begin
                e_req  = 1'b1;
                e_addr = m_pend_addr;
            end else begin
                room   = (out_addr_q.size() < NUM_REQS) &&
                         (r_br || (out_addr_q.size() + popc(r_fb) < NUM_REQS));
                e_req  = (r_req || r_br) && room;
                e_addr = r_br ? {r_ba[31:2], 2'b00} : m_fetch;
            end
            e_valid = r_rv && !r_br && !out_stale_q[0];
            e_busy  = m_pend || e_req || (out_addr_q.size() > 0);

            @(negedge clk);
            n_cmp++; if (bus.instr_req_o !== e_req) begin
                n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.instr_req_o, e_req); end
            if (e_req) begin
                n_cmp++; if (bus.instr_addr_o !== e_addr) begin
                    n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.instr_addr_o, e_addr); end
            end
            n_cmp++; if (bus.fifo_valid_o !== e_valid) begin
                n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.fifo_valid_o, e_valid); end
            if (e_valid) begin
                n_cmp++; if (bus.fifo_rdata_o !== r_rd || bus.fifo_err_o !== r_err) begin
                    n_fail++; $display("FAIL rnd_data c%0d: got %h/%b want %h/%b", c, bus.fifo_rdata_o, bus.fifo_err_o, r_rd, r_err); end
            end
            n_cmp++; if (bus.fifo_clear_o !== r_br || busy !== e_busy) begin
                n_fail++; $display("FAIL rnd_clr_busy c%0d: got %b/%b want %b/%b", c, bus.fifo_clear_o, busy, r_br, e_busy); end
            if (r_br) begin
                n_cmp++; if (bus.fifo_addr_o !== r_ba) begin
                    n_fail++; $display("FAIL rnd_faddr c%0d: got %h want %h", c, bus.fifo_addr_o, r_ba); end
            end

            // Model update for this clock edge.
            if (r_rv) begin
                if (!e_valid) m_drops++;
                void'(out_addr_q.pop_front());
                void'(out_stale_q.pop_front());
            end
            if (r_br) begin
                foreach (out_stale_q[i]) out_stale_q[i] = 1'b1;
                m_fetch = {r_ba[31:2], 2'b00};
            end
            if (e_req && r_gnt) begin
                if (m_pend) begin
                    st = m_pend_stale || r_br;
                    out_addr_q.push_back(m_pend_addr);
                    out_stale_q.push_back(st);
                    if (!st) m_fetch = m_pend_addr + 32'd4;
                    m_pend = 1'b0;
                end else begin
                    out_addr_q.push_back(e_addr);
                    out_stale_q.push_back(1'b0);
                    m_fetch = e_addr + 32'd4;
                end
            end else if (e_req) begin
                if (m_pend) begin
                    m_pend_stale = m_pend_stale || r_br;
                end else begin
                    m_pend       = 1'b1;
                    m_pend_addr  = e_addr;
                    m_pend_stale = 1'b0;
                end
            end
            tick();
        end

        drive(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        @(negedge clk);
`ifdef IBEX_FETCH_DISCARD_CNT_EN
        exp_d = 16'(m_drops);
`else
        exp_d = 16'd0;
`endif
        n_cmp++; if (disc_cnt !== exp_d) begin n_fail++; $display("FAIL rnd_disc_cnt: got %0d want %0d", disc_cnt, exp_d); end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        drive(0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        test_reset();
        test_sequential();
        test_max_outstanding();
        test_fifo_busy();
        test_branch_discard();
        test_pending_branch();
        test_wrap_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
